// File: rtl/pulse_gen_pkg.sv
// Shared encodings for the multi-channel edge-to-pulse generator.
package pulse_gen_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_OFF  = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/pulse_chan.sv
// One pulse channel: input synchroniser, history flop, edge select, pulse FSM with down-counter.
//  state     | meaning
//  ST_IDLE   | output low, waiting for a selected edge
//  ST_ACTIVE | output high, cnt counts down to terminal count 0
module pulse_chan
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             signal_in,
  input  logic             armed,
  input  logic [1:0]       edge_sel,
  input  logic             retrig,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic             overrun_clr,
  output logic             pulse_out,
  output logic             overrun
);

  logic             s;
  logic             s_d;
  logic             edge_hit;
  logic [CNT_W-1:0] width_eff;
  logic [CNT_W-1:0] load_val;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovr_d;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= signal_in;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign s = signal_in;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_d <= 1'b0;
    else        s_d <= s;
  end

  always_comb begin
    edge_hit = 1'b0;
    case (edge_sel)
      EDGE_RISE: edge_hit = s & ~s_d;
      EDGE_FALL: edge_hit = ~s & s_d;
      EDGE_BOTH: edge_hit = s ^ s_d;
      EDGE_OFF:  edge_hit = 1'b0;
      default:   edge_hit = 1'b0;
    endcase
    edge_hit = edge_hit & armed;
  end

  assign width_eff = (pulse_width == '0) ? CNT_W'(1) : pulse_width;
  assign load_val  = width_eff - CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      overrun <= ovr_d;
    end
  end

  // A dropped edge in the same cycle as overrun_clr leaves the bit set.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovr_d   = overrun;
    if (overrun_clr) ovr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (edge_hit) begin
          state_d = ST_ACTIVE;
          cnt_d   = load_val;
        end
      end
      ST_ACTIVE: begin
        if (edge_hit && retrig) begin
          cnt_d = load_val;
        end else begin
          if (edge_hit) ovr_d = 1'b1;
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pulse_out = (state_q == ST_ACTIVE);

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-channel edge-to-pulse generator: shared arming counter plus one pulse_chan per input.
module multi_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] signal_in,
  input  logic [1:0]          edge_sel,
  input  logic                retrig,
  input  logic [CNT_W-1:0]    pulse_width,
  input  logic                overrun_clr,
  output logic [CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] overrun
);

  localparam int              ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_INIT = ARM_W'(SYNC_STAGES + 1);

  logic [ARM_W-1:0] arm_cnt;
  logic             armed;

  // Holds off edge detection until the synchroniser and history flops carry real input data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              arm_cnt <= ARM_INIT;
    else if (arm_cnt != '0)  arm_cnt <= arm_cnt - ARM_W'(1);
  end

  assign armed = (arm_cnt == '0);

  generate
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
      pulse_chan #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
        .clk         (clk),
        .rst_n       (rst_n),
        .signal_in   (signal_in[ch]),
        .armed       (armed),
        .edge_sel    (edge_sel),
        .retrig      (retrig),
        .pulse_width (pulse_width),
        .overrun_clr (overrun_clr),
        .pulse_out   (pulse_out[ch]),
        .overrun     (overrun[ch])
      );
    end
  endgenerate

  assign busy = pulse_out;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Self-checking bench for multi_pulse_gen: directed scenarios plus random traffic against a remaining-cycles model.
module tb_multi_pulse_gen;
  import pulse_gen_pkg::*;

  localparam int CH = 4;
  localparam int CW = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] signal_in = '0;
  logic [1:0]    edge_sel = EDGE_RISE;
  logic          retrig = 1'b0;
  logic [CW-1:0] pulse_width = 4'd2;
  logic          overrun_clr = 1'b0;
  logic [CH-1:0] pulse_out, busy, overrun;

  int checks = 0;
  int errors = 0;

  // Model: input history since reset release, and per channel the number of high cycles still owed.
  logic [CH-1:0] xq[$];
  int            rem[CH];
  logic [CH-1:0] m_ov;
  logic [CH-1:0] m_out;

  int            hi_cnt[CH];
  int            npulse[CH];
  int            first_hi[CH];
  int            win_idx;
  logic [CH-1:0] prev_out;

  multi_pulse_gen #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .signal_in   (signal_in),
    .edge_sel    (edge_sel),
    .retrig      (retrig),
    .pulse_width (pulse_width),
    .overrun_clr (overrun_clr),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] x_at(input int j);
    if (j >= 1 && j <= xq.size()) return xq[j-1];
    return '0;
  endfunction

  task automatic model_reset();
    xq.delete();
    for (int c = 0; c < CH; c++) rem[c] = 0;
    m_ov  = '0;
    m_out = '0;
  endtask

  task automatic model_step();
    logic [CH-1:0] cur, old;
    int            e, w;
    logic          ev;
    xq.push_back(signal_in);
    e   = xq.size();
    cur = x_at(e - SS);
    old = x_at(e - SS - 1);
    w   = (pulse_width == 0) ? 1 : int'(pulse_width);
    if (overrun_clr) m_ov = '0;
    for (int c = 0; c < CH; c++) begin
      case (edge_sel)
        EDGE_RISE: ev = cur[c] && !old[c];
        EDGE_FALL: ev = !cur[c] && old[c];
        EDGE_BOTH: ev = cur[c] != old[c];
        default:   ev = 1'b0;
      endcase
      if (e <= SS + 1) ev = 1'b0;
      if (ev && rem[c] > 0) begin
        if (retrig) rem[c] = w;
        else begin
          m_ov[c] = 1'b1;
          rem[c]  = rem[c] - 1;
        end
      end else if (ev) begin
        rem[c] = w;
      end else if (rem[c] > 0) begin
        rem[c] = rem[c] - 1;
      end
      m_out[c] = rem[c] > 0;
    end
  endtask

  task automatic clear_tally();
    for (int c = 0; c < CH; c++) begin
      hi_cnt[c]   = 0;
      npulse[c]   = 0;
      first_hi[c] = 0;
    end
    win_idx = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    win_idx++;
    for (int c = 0; c < CH; c++) begin
      if (pulse_out[c]) hi_cnt[c]++;
      if (pulse_out[c] && !prev_out[c]) npulse[c]++;
      if (pulse_out[c] && first_hi[c] == 0) first_hi[c] = win_idx;
    end
    prev_out = pulse_out;
    chk("pulse_out", pulse_out, m_out);
    chk("busy", busy, m_out);
    chk("overrun", overrun, m_ov);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    prev_out = '0;
  endtask

  initial begin
    prev_out = '0;
    model_reset();
    clear_tally();
    do_reset();
    chk("reset_pulse_out", pulse_out, 0);
    chk("reset_overrun", overrun, 0);

    // 1: width 2, rise on ch0 -> high on cycles 3 and 4 after the change
    steps(4);
    clear_tally();
    signal_in[0] = 1'b1;
    steps(8);
    chk("t1_hi_ch0", hi_cnt[0], 2);
    chk("t1_first_ch0", first_hi[0], 3);
    chk("t1_others", hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);

    // 2: retrigger three cycles into a 5-cycle pulse -> 8 continuous cycles
    signal_in[0] = 1'b0;
    steps(8);
    pulse_width = 4'd5;
    retrig = 1'b1;
    clear_tally();
    signal_in[0] = 1'b1; step();
    signal_in[0] = 1'b0; steps(2);
    signal_in[0] = 1'b1; steps(12);
    chk("t2_hi", hi_cnt[0], 8);
    chk("t2_npulse", npulse[0], 1);

    // 3: same stimulus without retrigger -> 5 cycles, overrun set
    signal_in[0] = 1'b0;
    retrig = 1'b0;
    steps(8);
    clear_tally();
    signal_in[0] = 1'b1; step();
    signal_in[0] = 1'b0; steps(2);
    signal_in[0] = 1'b1; steps(12);
    chk("t3_hi", hi_cnt[0], 5);
    chk("t3_npulse", npulse[0], 1);
    chk("t3_overrun", overrun[0], 1);
    overrun_clr = 1'b1; step();
    overrun_clr = 1'b0;
    chk("t3_clr", overrun[0], 0);
    signal_in[0] = 1'b0;
    steps(8);
    signal_in[0] = 1'b1; step();
    signal_in[0] = 1'b0; steps(2);
    signal_in[0] = 1'b1; steps(2);
    overrun_clr = 1'b1; step();
    overrun_clr = 1'b0;
    chk("t3_set_wins", overrun[0], 1);
    steps(6);

    // 4: both edges / fall only / disabled on ch2
    edge_sel = EDGE_BOTH;
    pulse_width = 4'd1;
    clear_tally();
    signal_in[2] = 1'b1; steps(4);
    signal_in[2] = 1'b0; steps(10);
    chk("t4_both_hi", hi_cnt[2], 2);
    chk("t4_both_np", npulse[2], 2);
    edge_sel = EDGE_FALL;
    clear_tally();
    signal_in[2] = 1'b1; steps(4);
    signal_in[2] = 1'b0; steps(10);
    chk("t4_fall_hi", hi_cnt[2], 1);
    chk("t4_fall_first", first_hi[2], 7);
    edge_sel = EDGE_OFF;
    clear_tally();
    signal_in[2] = 1'b1; steps(4);
    signal_in[2] = 1'b0; steps(10);
    chk("t4_off_hi", hi_cnt[2], 0);

    // 5: inputs high through reset release, then zero width
    edge_sel = EDGE_RISE;
    pulse_width = 4'd2;
    signal_in = '1;
    do_reset();
    clear_tally();
    steps(10);
    chk("t5_no_false", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);
    pulse_width = 4'd0;
    signal_in[1] = 1'b0; steps(4);
    clear_tally();
    signal_in[1] = 1'b1; steps(6);
    chk("t5_w0_hi", hi_cnt[1], 1);

    // 6: async reset while all channels pulse, then re-arm
    signal_in = '0;
    pulse_width = 4'd3;
    steps(4);
    signal_in = '1;
    steps(4);
    chk("t6_all_active", pulse_out, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pulse", pulse_out, 0);
    chk("t6_rst_busy", busy, 0);
    do_reset();
    signal_in = '0;
    pulse_width = 4'd2;
    steps(4);
    clear_tally();
    signal_in[3] = 1'b1;
    steps(8);
    chk("t6_rearm_hi", hi_cnt[3], 2);
    chk("t6_rearm_first", first_hi[3], 3);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(4, 0) == 0) signal_in[c] = ~signal_in[c];
      if ($urandom_range(15, 0) == 0) edge_sel = 2'($urandom_range(3, 0));
      if ($urandom_range(7, 0) == 0)  retrig = 1'($urandom_range(1, 0));
      pulse_width = 4'($urandom_range(15, 0));
      overrun_clr = ($urandom_range(9, 0) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
